// File: rtl/ram_1w_nr_clr.sv
// rtl/ram_1w_nr_clr.sv - masked-write, N-read-port RAM with read latency, read-under-write policy and zero-fill clear engine
module ram_1w_nr_clr #(
  parameter int    wordCount      = 256,
  parameter int    wordWidth      = 64,
  parameter int    addressWidth   = 8,
  parameter int    readPorts      = 2,
  parameter int    maskWidth      = 8,
  parameter int    rdLatency      = 1,
  parameter string readUnderWrite = "writeFirst"
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr_start,
  output logic                              clr_busy,
  input  logic                              wr_en,
  input  logic [maskWidth-1:0]              wr_mask,
  input  logic [addressWidth-1:0]           wr_addr,
  input  logic [wordWidth-1:0]              wr_data,
  input  logic [readPorts-1:0]              rd_en,
  input  logic [readPorts*addressWidth-1:0] rd_addr,
  output logic [readPorts*wordWidth-1:0]    rd_data,
  output logic [readPorts-1:0]              rd_valid
);

  localparam int lane_width = wordWidth / maskWidth;
  localparam logic [addressWidth:0]   word_count_ext = (addressWidth + 1)'(wordCount);
  localparam logic [addressWidth-1:0] last_addr      = addressWidth'(wordCount - 1);
  // readFirst and dontCare share the cheaper pre-write data path
  localparam bit write_first = (readUnderWrite == "writeFirst");

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] cnt_q, cnt_d;
  logic                    clr_busy_q, clr_busy_d;

  logic [wordWidth-1:0] mem_q [wordCount];

  logic                    user_owns;
  logic [wordWidth-1:0]    wr_bitmask;
  logic                    wr_hit;
  logic                    mem_we;
  logic [addressWidth-1:0] mem_waddr;
  logic [wordWidth-1:0]    mem_wdata;
  logic [maskWidth-1:0]    mem_lane_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_d = clr_busy_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == last_addr) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          clr_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          clr_busy_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      clr_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  assign clr_busy = clr_busy_q;

  // The clear engine takes the write port outright; user writes in CLEAR are dropped
  always_comb begin
    user_owns  = (state_q == ST_IDLE);
    wr_bitmask = '0;
    for (int i = 0; i < maskWidth; i++) begin
      wr_bitmask[i*lane_width +: lane_width] = {lane_width{wr_mask[i]}};
    end
    wr_hit = user_owns && wr_en && ({1'b0, wr_addr} < word_count_ext) && (wr_mask != '0);
    if (user_owns) begin
      mem_we      = wr_hit;
      mem_waddr   = wr_addr;
      mem_wdata   = wr_data;
      mem_lane_en = wr_mask;
    end else begin
      mem_we      = 1'b1;
      mem_waddr   = cnt_q;
      mem_wdata   = '0;
      mem_lane_en = '1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < maskWidth; i++) begin
      if (mem_we && mem_lane_en[i]) begin
        mem_q[mem_waddr][i*lane_width +: lane_width] <= mem_wdata[i*lane_width +: lane_width];
      end
    end
  end

  for (genvar p = 0; p < readPorts; p++) begin : g_rd
    logic [addressWidth-1:0] addr;
    logic                    in_range;
    logic                    fire;
    logic                    collide;
    logic [wordWidth-1:0]    word;
    logic                    s1_valid_q, s1_valid_d;
    logic [wordWidth-1:0]    s1_data_q, s1_data_d;

    always_comb begin
      addr     = rd_addr[p*addressWidth +: addressWidth];
      in_range = ({1'b0, addr} < word_count_ext);
      fire     = user_owns && rd_en[p];
      collide  = write_first && wr_hit && (addr == wr_addr);
      word     = '0;
      if (in_range) begin
        word = mem_q[addr];
      end
      if (collide) begin
        word = (word & ~wr_bitmask) | (wr_data & wr_bitmask);
      end
      s1_valid_d = fire;
      s1_data_d  = fire ? word : s1_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    if (rdLatency == 2) begin : g_lat2
      logic                 s2_valid_q, s2_valid_d;
      logic [wordWidth-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign rd_valid[p]                     = s2_valid_q;
      assign rd_data[p*wordWidth +: wordWidth] = s2_data_q;
    end else begin : g_lat1
      assign rd_valid[p]                     = s1_valid_q;
      assign rd_data[p*wordWidth +: wordWidth] = s1_data_q;
    end
  end

endmodule

// File: tb/tb_ram_1w_nr_clr.sv
// tb/tb_ram_1w_nr_clr.sv - randomized and directed bench for ram_1w_nr_clr against a behavioural model
module tb_ram_1w_nr_clr;

  logic clk = 1'b0;
  logic reset;

  logic         clr_start [2];
  logic         clr_busy  [2];
  logic         wr_en     [2];
  logic [7:0]   wr_mask   [2];
  logic [7:0]   wr_addr   [2];
  logic [63:0]  wr_data   [2];
  logic [1:0]   rd_en     [2];
  logic [15:0]  rd_addr   [2];
  logic [127:0] rd_data   [2];
  logic [1:0]   rd_valid  [2];

  always #5 clk = ~clk;

  ram_1w_nr_clr #(
    .wordCount(256), .wordWidth(64), .addressWidth(8), .readPorts(2),
    .maskWidth(8), .rdLatency(1), .readUnderWrite("writeFirst")
  ) dut_a (
    .clk(clk), .reset(reset), .clr_start(clr_start[0]), .clr_busy(clr_busy[0]),
    .wr_en(wr_en[0]), .wr_mask(wr_mask[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0])
  );

  ram_1w_nr_clr #(
    .wordCount(200), .wordWidth(64), .addressWidth(8), .readPorts(2),
    .maskWidth(8), .rdLatency(2), .readUnderWrite("readFirst")
  ) dut_b (
    .clk(clk), .reset(reset), .clr_start(clr_start[1]), .clr_busy(clr_busy[1]),
    .wr_en(wr_en[1]), .wr_mask(wr_mask[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1])
  );

  int n_checks;
  int n_errors;

  // Reference model: contents, remaining clear cycles, and the read pipeline per instance
  logic [63:0] m_mem       [2][256];
  int          m_left      [2];
  logic [63:0] m_s1_data   [2][2];
  logic        m_s1_valid  [2][2];
  logic [63:0] m_out_data  [2][2];
  logic        m_out_valid [2][2];

  function automatic int wc_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit wf_of(input int d);
    return (d == 0);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_zero(input int d);
    for (int a = 0; a < 256; a++) m_mem[d][a] = 64'h0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = wc_of(d);
      model_zero(d);
      for (int p = 0; p < 2; p++) begin
        m_s1_data[d][p]   = 64'h0;
        m_s1_valid[d][p]  = 1'b0;
        m_out_data[d][p]  = 64'h0;
        m_out_valid[d][p] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int d);
    logic [63:0] bm;
    logic [63:0] res [2];
    logic        rv  [2];
    logic        wr_ok;
    int          wa;
    int          ra;
    for (int p = 0; p < 2; p++) begin
      res[p] = 64'h0;
      rv[p]  = 1'b0;
    end
    if (m_left[d] > 0) begin
      m_left[d]--;
    end else begin
      for (int i = 0; i < 8; i++) bm[i*8 +: 8] = {8{wr_mask[d][i]}};
      wa    = int'(wr_addr[d]);
      wr_ok = wr_en[d] && (wa < wc_of(d));
      for (int p = 0; p < 2; p++) begin
        if (rd_en[d][p]) begin
          rv[p] = 1'b1;
          ra    = int'(rd_addr[d][p*8 +: 8]);
          if (ra < wc_of(d)) begin
            res[p] = m_mem[d][ra];
            if (wf_of(d) && wr_ok && ra == wa) res[p] = (res[p] & ~bm) | (wr_data[d] & bm);
          end
        end
      end
      if (wr_ok) m_mem[d][wa] = (m_mem[d][wa] & ~bm) | (wr_data[d] & bm);
      if (clr_start[d]) begin
        m_left[d] = wc_of(d);
        model_zero(d);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (lat_of(d) == 1) begin
        m_out_valid[d][p] = rv[p];
        if (rv[p]) m_out_data[d][p] = res[p];
      end else begin
        m_out_valid[d][p] = m_s1_valid[d][p];
        if (m_s1_valid[d][p]) m_out_data[d][p] = m_s1_data[d][p];
        m_s1_valid[d][p] = rv[p];
        if (rv[p]) m_s1_data[d][p] = res[p];
      end
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      clr_start[d] = 1'b0;
      wr_en[d]     = 1'b0;
      wr_mask[d]   = 8'h00;
      wr_addr[d]   = 8'h00;
      wr_data[d]   = 64'h0;
      rd_en[d]     = 2'b00;
      rd_addr[d]   = 16'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_busy", d), 64'(clr_busy[d]), 64'(m_left[d] > 0));
      for (int p = 0; p < 2; p++) begin
        check_eq($sformatf("d%0d_p%0d_valid", d, p), 64'(rd_valid[d][p]), 64'(m_out_valid[d][p]));
        check_eq($sformatf("d%0d_p%0d_data", d, p), rd_data[d][p*64 +: 64], m_out_data[d][p]);
      end
    end
  endtask

  // Counts busy cycles per instance until both are idle; stimulus is applied only on the first cycle
  task automatic run_clear(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < 700 && (clr_busy[0] || clr_busy[1]); k++) begin
      if (clr_busy[0]) na++;
      if (clr_busy[1]) nb++;
      tick();
      idle_all();
    end
    if (clr_busy[0] || clr_busy[1]) check_eq("clear_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [7:0] raddr();
    case ($urandom_range(0, 3))
      0:       return 8'd9;
      1:       return 8'($urandom_range(0, 3));
      2:       return 8'($urandom_range(196, 255));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int na;
    int nb;
    logic [7:0] a8;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle_all();
    model_reset();
    tick();
    tick();

    reset = 1'b0;
    run_clear(na, nb);
    check_eq("post_reset_clear_len_a", 64'(na), 64'd256);
    check_eq("post_reset_clear_len_b", 64'(nb), 64'd200);

    for (int i = 0; i < 3; i++) begin
      a8 = (i == 0) ? 8'd0 : (i == 1) ? 8'd128 : 8'd255;
      rd_en[0]   = 2'b11;
      rd_addr[0] = {a8, a8};
      tick();
      idle_all();
      check_eq("cleared_rd_valid", 64'(rd_valid[0]), 64'd3);
      check_eq("cleared_rd_p0", rd_data[0][63:0], 64'h0);
      check_eq("cleared_rd_p1", rd_data[0][127:64], 64'h0);
    end

    wr_en[0] = 1'b1; wr_addr[0] = 8'd5; wr_mask[0] = 8'hFF; wr_data[0] = 64'h1122334455667788;
    tick();
    wr_mask[0] = 8'h0F; wr_data[0] = 64'hAAAAAAAAAAAAAAAA;
    tick();
    idle_all();
    rd_en[0] = 2'b11; rd_addr[0] = {8'd5, 8'd5};
    tick();
    idle_all();
    check_eq("masked_p0", rd_data[0][63:0], 64'h11223344AAAAAAAA);
    check_eq("masked_p1", rd_data[0][127:64], 64'h11223344AAAAAAAA);

    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 1'b1; wr_addr[d] = 8'd9; wr_mask[d] = 8'hFF; wr_data[d] = 64'hDEAD;
      rd_en[d] = 2'b01; rd_addr[d] = {8'd0, 8'd9};
    end
    tick();
    idle_all();
    check_eq("ruw_write_first", rd_data[0][63:0], 64'hDEAD);
    tick();
    check_eq("ruw_read_first", rd_data[1][63:0], 64'h0);
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 2'b01; rd_addr[d] = {8'd0, 8'd9};
    end
    tick();
    idle_all();
    check_eq("ruw_later_a", rd_data[0][63:0], 64'hDEAD);
    tick();
    check_eq("ruw_later_b", rd_data[1][63:0], 64'hDEAD);

    wr_en[1] = 1'b1; wr_mask[1] = 8'hFF; wr_addr[1] = 8'd1; wr_data[1] = 64'h1111111111111111;
    tick();
    wr_addr[1] = 8'd2; wr_data[1] = 64'h2222222222222222;
    tick();
    idle_all();
    rd_en[1] = 2'b11; rd_addr[1] = {8'd2, 8'd1};
    tick();
    idle_all();
    check_eq("lat2_not_early", 64'(rd_valid[1]), 64'd0);
    tick();
    check_eq("lat2_valid", 64'(rd_valid[1]), 64'd3);
    check_eq("lat2_p0", rd_data[1][63:0], 64'h1111111111111111);
    check_eq("lat2_p1", rd_data[1][127:64], 64'h2222222222222222);
    tick();
    check_eq("lat2_idle_valid", 64'(rd_valid[1]), 64'd0);
    check_eq("lat2_hold_p1", rd_data[1][127:64], 64'h2222222222222222);

    wr_en[0] = 1'b1; wr_mask[0] = 8'hFF; wr_addr[0] = 8'd3; wr_data[0] = 64'h55;
    tick();
    idle_all();
    clr_start[0] = 1'b1;
    tick();
    wr_en[0] = 1'b1; wr_mask[0] = 8'hFF; wr_addr[0] = 8'd3; wr_data[0] = 64'h77;
    clr_start[0] = 1'b1;
    run_clear(na, nb);
    check_eq("interfered_clear_len", 64'(na), 64'd256);
    rd_en[0] = 2'b01; rd_addr[0] = {8'd0, 8'd3};
    tick();
    idle_all();
    check_eq("interfered_addr3", rd_data[0][63:0], 64'h0);

    clr_start[1] = 1'b1;
    tick();
    idle_all();
    repeat (99) tick();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    run_clear(na, nb);
    check_eq("mid_clear_reset_len_b", 64'(nb), 64'd200);
    wr_en[1] = 1'b1; wr_mask[1] = 8'hFF; wr_addr[1] = 8'd250; wr_data[1] = 64'hBEEF;
    tick();
    idle_all();
    rd_en[1] = 2'b11; rd_addr[1] = {8'd199, 8'd250};
    tick();
    idle_all();
    tick();
    check_eq("oor_valid", 64'(rd_valid[1]), 64'd3);
    check_eq("oor_data", rd_data[1][63:0], 64'h0);

    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        clr_start[d] = ($urandom_range(0, 599) == 0);
        wr_en[d]     = 1'($urandom_range(0, 1));
        wr_mask[d]   = 8'($urandom);
        wr_addr[d]   = raddr();
        wr_data[d]   = {$urandom, $urandom};
        rd_en[d]     = 2'($urandom);
        rd_addr[d]   = {raddr(), raddr()};
      end
      tick();
    end
    idle_all();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_1w_nr_clr.md
Name: ram_1w_nr_clr

Overview:
- Single-clock RAM with one masked write port and N independent registered read ports.
- Adds configurable read latency and a selectable read-under-write policy.
- Adds a built-in clear engine that zero-fills the array after reset or on request.
- Sits beside the SpinalHDL memory blackboxes in the ECI path, for tag and metadata tables that must start from a known all-zero state and be read by several consumers per cycle.

Parameters:
- wordCount, 256, number of words; need not be a power of two.
- wordWidth, 64, bits per word.
- addressWidth, 8, address bits; must satisfy 2^addressWidth >= wordCount.
- readPorts, 2, number of read ports; range 1..4.
- maskWidth, 8, write-mask lanes; wordWidth must be divisible by maskWidth; lane width = wordWidth/maskWidth.
- rdLatency, 1, read latency in cycles; 1 or 2 (2 adds an output register stage).
- readUnderWrite, "writeFirst", one of "writeFirst", "readFirst", "dontCare".

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- clr_start  in  1  single-cycle request to zero-fill the array.
- clr_busy  out  1  high while the clear engine owns the array.
- wr_en  in  1  write strobe.
- wr_mask  in  maskWidth  per-lane write enable.
- wr_addr  in  addressWidth  write address.
- wr_data  in  wordWidth  write data.
- rd_en  in  readPorts  per-port read strobe.
- rd_addr  in  readPorts*addressWidth  port p uses bits [p*addressWidth +: addressWidth].
- rd_data  out  readPorts*wordWidth  port p uses bits [p*wordWidth +: wordWidth].
- rd_valid  out  readPorts  per-port data-valid flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: clr_busy=1, rd_valid=0, rd_data=0, clear counter=0, FSM=CLEAR. The array contents are not reset; the clear engine zeroes them.
- FSM state CLEAR: each cycle writes 0 to address cnt across all lanes, then cnt++. At cnt==wordCount-1, the write happens, the FSM moves to IDLE and cnt returns to 0.
- Clear timing: exactly wordCount cycles. clr_busy is 1 through the cycle that writes the last word and is 0 on the following cycle.
- FSM state IDLE: clr_busy=0. clr_start=1 moves the FSM to CLEAR on the next edge with cnt=0. clr_start while in CLEAR is ignored; it neither restarts nor extends the clear.
- Reset mid-clear: the FSM returns to CLEAR with cnt=0 and clears the full array again.
- User access during CLEAR: wr_en is ignored and dropped, not queued. rd_en is ignored, so rd_valid stays 0 for reads issued in CLEAR. Reads already in the pipeline when CLEAR starts still complete.
- Write: when wr_en=1 in IDLE, lane i of word wr_addr takes wr_data lane i where wr_mask[i]=1; lanes with wr_mask[i]=0 are unchanged. wr_mask=0 writes nothing.
- Read: rd_en[p]=1 at edge t loads rd_data[p] with the word at rd_addr[p] and sets rd_valid[p]=1 at edge t+rdLatency. With rdLatency=2 the word is captured at t+1 and re-registered at t+2.
- Read idle: rd_en[p]=0 gives rd_valid[p]=0 at the matching edge; rd_data[p] holds its last value.
- Ports are fully independent; any number of ports may read the same address in the same cycle.
- Read-under-write: applies when a read and a write hit the same address at the same edge.
  - writeFirst: the read returns the merged word, i.e. new lanes where the mask is 1 and old lanes elsewhere.
  - readFirst: the read returns the pre-write word.
  - dontCare: the returned data is unspecified, but rd_valid is still correct.
- Out-of-range address (>= wordCount): writes are discarded; reads return 0 with rd_valid=1.
- No combinational path from any input to any output.

Test Plan:
- Post-reset clear, wordCount=256: release reset -> clr_busy=1 for exactly 256 cycles, then 0. Reading addresses 0, 128 and 255 on both ports -> rd_data=0, rd_valid=1 one cycle later.
- Masked write, wordWidth=64, maskWidth=8: write 0x1122334455667788 to addr 5 with mask 0xFF, then 0xAAAAAAAAAAAAAAAA with mask 0x0F. Read addr 5 -> 0x11223344AAAAAAAA.
- Read-under-write, same edge, addr 9 holding 0x0 and write 0xDEAD mask 0xFF: port 0 reads addr 9 -> 0xDEAD in writeFirst, 0x0 in readFirst. A later read -> 0xDEAD in both modes.
- Latency and independence, rdLatency=2: port 0 reads addr 1 and port 1 reads addr 2 on the same edge. Both rd_valid rise exactly 2 cycles later with the correct words; rd_en=0 the next cycle -> rd_valid=0 and rd_data held.
- Clear with interference: in IDLE, set addr 3 to 0x55, pulse clr_start, then issue a write to addr 3 and a clr_start during CLEAR. The write is dropped, clr_busy lasts 256 cycles, and a later read of addr 3 -> 0.
- Reset mid-clear and out-of-range, wordCount=200: assert reset at clear cycle 100 -> clr_busy stays high for a full 200 cycles after release. Write to addr 250 is discarded; reading addr 250 -> 0 with rd_valid=1.
